// File: rtl/imem_stage_pkg.sv
// Shared types for the memory stage: access-size and write-back-select codes,
// FSM state, and the captured-instruction / write-back register layouts.
package imem_stage_pkg;

  typedef enum logic [1:0] {MEM_BYTE = 2'b00, MEM_HALF = 2'b01, MEM_WORD = 2'b10} mem_size_e;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10, WB_IMM = 2'b11} wbsel_e;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [31:0] sdata;
    logic [1:0]  wbsel;
    logic [4:0]  rdst;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_signed;
    logic        halt;
    logic [1:0]  size;
  } mem_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [31:0] ld;
    logic [1:0]  wbsel;
    logic [4:0]  rdst;
    logic        wen;
    logic        halt;
    logic        fault;
  } wb_t;

  // Size code 11 falls into the word rule.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return lsb[0];
      default:  return |lsb;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed lane of a read word and zero/sign-extends it to 32 bits.
module load_align
  import imem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      MEM_BYTE: ext = {{24{is_signed & b[7]}}, b};
      MEM_HALF: ext = {{16{is_signed & h[15]}}, h};
      default:  ext = rdata;
    endcase
  end

endmodule

// File: rtl/imem_stage.sv
// Pipeline memory stage: passes non-memory ops through in one cycle, runs loads and
// stores as a blocking bus transaction with a timeout, and reports alignment/bus faults.
module imem_stage
  import imem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid_in_mem,
  input  logic [31:0] PC_in_mem,
  input  logic [31:0] Inst_in_mem,
  input  logic [31:0] ALUOutput_in_mem,
  input  logic [31:0] Immediate_in_mem,
  input  logic [31:0] StoreData_in_mem,
  input  logic [1:0]  WBSel_in_mem,
  input  logic [4:0]  Rdst_in_mem,
  input  logic        RegWrite_in_mem,
  input  logic        MemRead_in_mem,
  input  logic        MemWrite_in_mem,
  input  logic        MemSigned_in_mem,
  input  logic        halt_in_mem,
  input  logic [1:0]  MemSize_in_mem,
  output logic        stall_out_mem,
  output logic        DMEM_req,
  output logic        DMEM_we,
  output logic [31:0] DMEM_addr,
  output logic [31:0] DMEM_wdata,
  output logic [3:0]  DMEM_be,
  input  logic        DMEM_ack,
  input  logic [31:0] DMEM_rdata,
  output logic [31:0] PC_out_mem,
  output logic [31:0] Inst_out_mem,
  output logic [31:0] ALUOutput_out_mem,
  output logic [31:0] Immediate_out_mem,
  output logic [31:0] LoadExtended_out_mem,
  output logic [1:0]  WBSel_out_mem,
  output logic [4:0]  Rdst_out_mem,
  output logic        WEN_out_mem,
  output logic        halt_out_mem,
  output logic        fault_out_mem
);

  state_t      state;
  logic [7:0]  tmo_cnt;
  mem_op_t     in_op, cap, src;
  wb_t         wb_q, wb_d;
  logic        busy, idle_v, is_mem, misal, start, tmo_hit, flt, take;
  logic [31:0] ld_ext, wd;
  logic [3:0]  be;

  always_comb begin
    in_op.pc         = PC_in_mem;
    in_op.inst       = Inst_in_mem;
    in_op.alu        = ALUOutput_in_mem;
    in_op.imm        = Immediate_in_mem;
    in_op.sdata      = StoreData_in_mem;
    in_op.wbsel      = WBSel_in_mem;
    in_op.rdst       = Rdst_in_mem;
    in_op.reg_write  = RegWrite_in_mem;
    in_op.mem_read   = MemRead_in_mem;
    in_op.mem_write  = MemWrite_in_mem;
    in_op.mem_signed = MemSigned_in_mem;
    in_op.halt       = halt_in_mem;
    in_op.size       = MemSize_in_mem;
  end

  assign busy    = (state == BUSY);
  assign idle_v  = (state == IDLE) && valid_in_mem;
  assign is_mem  = in_op.mem_read | in_op.mem_write;
  assign misal   = misaligned(in_op.size, in_op.alu[1:0]);
  assign start   = idle_v && is_mem && !misal;
  // An ack in the final counted cycle takes priority over the timeout.
  assign tmo_hit = busy && !DMEM_ack && (tmo_cnt == 8'(TIMEOUT - 1));
  assign flt     = (idle_v && is_mem && misal) || tmo_hit;
  assign take    = (idle_v && !start) || (busy && DMEM_ack) || tmo_hit;
  assign src     = busy ? cap : in_op;

  assign stall_out_mem = start || (busy && !DMEM_ack && !tmo_hit);

  load_align u_load_align (
    .rdata     (DMEM_rdata),
    .addr      (cap.alu[1:0]),
    .size      (cap.size),
    .is_signed (cap.mem_signed),
    .ext       (ld_ext)
  );

  always_comb begin
    be = 4'b1111;
    wd = cap.sdata;
    if (cap.mem_write) begin
      case (cap.size)
        MEM_BYTE: begin be = 4'b0001 << cap.alu[1:0]; wd = {4{cap.sdata[7:0]}}; end
        MEM_HALF: begin be = cap.alu[1] ? 4'b1100 : 4'b0011; wd = {2{cap.sdata[15:0]}}; end
        default:  ;
      endcase
    end
  end

  assign DMEM_req   = busy;
  assign DMEM_we    = busy & cap.mem_write;
  assign DMEM_addr  = busy ? {cap.alu[31:2], 2'b00} : 32'd0;
  assign DMEM_wdata = busy ? wd : 32'd0;
  assign DMEM_be    = busy ? be : 4'd0;

  // Anything not taken this cycle loads a bubble.
  always_comb begin
    wb_d = '0;
    if (take) begin
      wb_d.pc    = src.pc;
      wb_d.inst  = src.inst;
      wb_d.alu   = src.alu;
      wb_d.imm   = src.imm;
      wb_d.wbsel = src.wbsel;
      wb_d.rdst  = src.rdst;
      wb_d.wen   = src.reg_write & ~flt;
      wb_d.halt  = src.halt | flt;
      wb_d.fault = flt;
      wb_d.ld    = (busy && src.mem_read && !flt) ? ld_ext : 32'd0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      cap     <= '0;
      wb_q    <= '0;
    end else begin
      wb_q <= wb_d;
      case (state)
        IDLE: if (start) begin
          cap     <= in_op;
          tmo_cnt <= '0;
          state   <= BUSY;
        end
        BUSY: if (DMEM_ack || tmo_hit) state <= IDLE;
              else tmo_cnt <= tmo_cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end

  assign PC_out_mem           = wb_q.pc;
  assign Inst_out_mem         = wb_q.inst;
  assign ALUOutput_out_mem    = wb_q.alu;
  assign Immediate_out_mem    = wb_q.imm;
  assign LoadExtended_out_mem = wb_q.ld;
  assign WBSel_out_mem        = wb_q.wbsel;
  assign Rdst_out_mem         = wb_q.rdst;
  assign WEN_out_mem          = wb_q.wen;
  assign halt_out_mem         = wb_q.halt;
  assign fault_out_mem        = wb_q.fault;

endmodule

// File: tb/tb_imem_stage.sv
// Randomized + directed bench for imem_stage against a behavioural model of the stage.
module tb_imem_stage;
  localparam int TIMEOUT = 4;

  typedef struct {
    logic [31:0] pc, inst, alu, imm, sd;
    logic [1:0]  wbsel, size;
    logic [4:0]  rdst;
    logic        rw, mr, mw, sg, halt;
  } op_t;

  logic        CLK = 1'b0, RST = 1'b0;
  logic        valid_in_mem = 1'b0;
  logic [31:0] PC_in_mem = '0, Inst_in_mem = '0, ALUOutput_in_mem = '0, Immediate_in_mem = '0, StoreData_in_mem = '0;
  logic [1:0]  WBSel_in_mem = '0, MemSize_in_mem = '0;
  logic [4:0]  Rdst_in_mem = '0;
  logic        RegWrite_in_mem = 0, MemRead_in_mem = 0, MemWrite_in_mem = 0, MemSigned_in_mem = 0, halt_in_mem = 0;
  logic        stall_out_mem, DMEM_req, DMEM_we, DMEM_ack = 1'b0;
  logic [31:0] DMEM_addr, DMEM_wdata, DMEM_rdata = '0;
  logic [3:0]  DMEM_be;
  logic [31:0] PC_out_mem, Inst_out_mem, ALUOutput_out_mem, Immediate_out_mem, LoadExtended_out_mem;
  logic [1:0]  WBSel_out_mem;
  logic [4:0]  Rdst_out_mem;
  logic        WEN_out_mem, halt_out_mem, fault_out_mem;
  logic [169:0] all_out;

  int checks = 0, failures = 0;

  assign all_out = {PC_out_mem, Inst_out_mem, ALUOutput_out_mem, Immediate_out_mem, LoadExtended_out_mem,
                    WBSel_out_mem, Rdst_out_mem, WEN_out_mem, halt_out_mem, fault_out_mem};

  always #5 CLK = ~CLK;

  imem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .valid_in_mem(valid_in_mem),
    .PC_in_mem(PC_in_mem), .Inst_in_mem(Inst_in_mem), .ALUOutput_in_mem(ALUOutput_in_mem),
    .Immediate_in_mem(Immediate_in_mem), .StoreData_in_mem(StoreData_in_mem), .WBSel_in_mem(WBSel_in_mem),
    .Rdst_in_mem(Rdst_in_mem), .RegWrite_in_mem(RegWrite_in_mem), .MemRead_in_mem(MemRead_in_mem),
    .MemWrite_in_mem(MemWrite_in_mem), .MemSigned_in_mem(MemSigned_in_mem), .halt_in_mem(halt_in_mem),
    .MemSize_in_mem(MemSize_in_mem), .stall_out_mem(stall_out_mem),
    .DMEM_req(DMEM_req), .DMEM_we(DMEM_we), .DMEM_addr(DMEM_addr), .DMEM_wdata(DMEM_wdata),
    .DMEM_be(DMEM_be), .DMEM_ack(DMEM_ack), .DMEM_rdata(DMEM_rdata),
    .PC_out_mem(PC_out_mem), .Inst_out_mem(Inst_out_mem), .ALUOutput_out_mem(ALUOutput_out_mem),
    .Immediate_out_mem(Immediate_out_mem), .LoadExtended_out_mem(LoadExtended_out_mem),
    .WBSel_out_mem(WBSel_out_mem), .Rdst_out_mem(Rdst_out_mem), .WEN_out_mem(WEN_out_mem),
    .halt_out_mem(halt_out_mem), .fault_out_mem(fault_out_mem)
  );

  // ---------------- reference model ----------------
  function automatic bit is_misaligned(op_t o);
    int a = int'(o.alu[1:0]);
    if (o.size == 2'd0) return 0;
    if (o.size == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] exp_load(logic [31:0] rdata, op_t o);
    logic [31:0] v = rdata >> (8 * int'(o.alu[1:0]));
    if (o.size == 2'd0) begin
      v = v & 32'hFF;
      if (o.sg && v >= 32'h80) v = v - 32'h100;
    end else if (o.size == 2'd1) begin
      v = v & 32'hFFFF;
      if (o.sg && v >= 32'h8000) v = v - 32'h10000;
    end else v = rdata;
    return v;
  endfunction

  function automatic logic [3:0] exp_be(op_t o);
    if (!o.mw || o.size >= 2'd2) return 4'hF;
    if (o.size == 2'd0) return 4'(1 << int'(o.alu[1:0]));
    return 4'(3 << int'(o.alu[1:0]));
  endfunction

  function automatic logic [31:0] exp_wdata(op_t o);
    if (o.size == 2'd0) return {24'd0, o.sd[7:0]} * 32'h01010101;
    if (o.size == 2'd1) return {16'd0, o.sd[15:0]} * 32'h00010001;
    return o.sd;
  endfunction

  function automatic op_t mk_op(bit mr, bit mw, logic [1:0] size, bit sg, logic [31:0] alu, logic [31:0] sd, bit rw);
    op_t o;
    o.pc = $urandom; o.inst = $urandom; o.imm = $urandom; o.wbsel = 2'($urandom); o.rdst = 5'($urandom);
    o.halt = 1'b0; o.mr = mr; o.mw = mw; o.size = size; o.sg = sg; o.alu = alu; o.sd = sd; o.rw = rw;
    return o;
  endfunction

  task automatic drive(op_t o);
    PC_in_mem = o.pc; Inst_in_mem = o.inst; ALUOutput_in_mem = o.alu; Immediate_in_mem = o.imm;
    StoreData_in_mem = o.sd; WBSel_in_mem = o.wbsel; Rdst_in_mem = o.rdst; RegWrite_in_mem = o.rw;
    MemRead_in_mem = o.mr; MemWrite_in_mem = o.mw; MemSigned_in_mem = o.sg; halt_in_mem = o.halt;
    MemSize_in_mem = o.size;
  endtask

  // Runs one instruction; the memory answers after d BUSY cycles without ack.
  task automatic exec_op(op_t o, int d, logic [31:0] rdata);
    bit memop, bad, tmo;
    int stalls, reqs;
    memop = o.mr | o.mw;
    bad   = memop && is_misaligned(o);
    tmo   = memop && !bad && d >= TIMEOUT;
    @(negedge CLK); drive(o); valid_in_mem = 1'b1; DMEM_ack = 1'b0; #1;
    stalls = int'(stall_out_mem); reqs = 0;
    checks++; if (stall_out_mem !== (memop && !bad)) begin failures++; $display("FAIL entry_stall: got %b want %b", stall_out_mem, memop && !bad); end
    checks++; if (DMEM_req !== 1'b0) begin failures++; $display("FAIL entry_req: got %b want 0", DMEM_req); end
    if (memop && !bad) begin
      for (int k = 1; k <= TIMEOUT; k++) begin
        @(negedge CLK); DMEM_ack = (k == d + 1); DMEM_rdata = DMEM_ack ? rdata : $urandom; #1;
        reqs += int'(DMEM_req);
        stalls += int'(stall_out_mem);
        if (k == 1) begin
          checks++; if (DMEM_we !== o.mw) begin failures++; $display("FAIL dmem_we: got %b want %b", DMEM_we, o.mw); end
          checks++; if (DMEM_addr !== (o.alu & 32'hFFFFFFFC)) begin failures++; $display("FAIL dmem_addr: got %h want %h", DMEM_addr, o.alu & 32'hFFFFFFFC); end
          checks++; if (DMEM_be !== exp_be(o)) begin failures++; $display("FAIL dmem_be: got %b want %b", DMEM_be, exp_be(o)); end
          if (o.mw) begin
            checks++; if (DMEM_wdata !== exp_wdata(o)) begin failures++; $display("FAIL dmem_wdata: got %h want %h", DMEM_wdata, exp_wdata(o)); end
          end
          checks++; if ({WEN_out_mem, fault_out_mem} !== 2'b00) begin failures++; $display("FAIL entry_bubble: got wen/fault %b want 00", {WEN_out_mem, fault_out_mem}); end
        end
        if (DMEM_ack) break;
      end
      checks++; if (reqs != (tmo ? TIMEOUT : d + 1)) begin failures++; $display("FAIL req_cycles: got %0d want %0d", reqs, tmo ? TIMEOUT : d + 1); end
      if (!tmo) begin
        checks++; if (stalls != d + 1) begin failures++; $display("FAIL stall_cycles: got %0d want %0d", stalls, d + 1); end
      end
    end
    @(negedge CLK); DMEM_ack = 1'b0; valid_in_mem = 1'b0; #1;
    checks++; if (DMEM_req !== 1'b0) begin failures++; $display("FAIL exit_req: got %b want 0", DMEM_req); end
    if (bad || tmo) begin
      checks++; if ({WEN_out_mem, fault_out_mem, halt_out_mem} !== 3'b011) begin failures++; $display("FAIL fault_out: got wen/fault/halt %b want 011", {WEN_out_mem, fault_out_mem, halt_out_mem}); end
    end else begin
      checks++; if ({WEN_out_mem, fault_out_mem, halt_out_mem} !== {o.rw, 1'b0, o.halt}) begin failures++; $display("FAIL ctrl_out: got wen/fault/halt %b want %b", {WEN_out_mem, fault_out_mem, halt_out_mem}, {o.rw, 1'b0, o.halt}); end
      checks++; if ({PC_out_mem, Inst_out_mem, ALUOutput_out_mem, Immediate_out_mem, WBSel_out_mem, Rdst_out_mem} !== {o.pc, o.inst, o.alu, o.imm, o.wbsel, o.rdst}) begin
        failures++; $display("FAIL fields_out: got pc %h alu %h rd %0d want pc %h alu %h rd %0d", PC_out_mem, ALUOutput_out_mem, Rdst_out_mem, o.pc, o.alu, o.rdst); end
      if (memop) begin
        checks++; if (LoadExtended_out_mem !== (o.mr ? exp_load(rdata, o) : 32'd0)) begin failures++; $display("FAIL load_ext: got %h want %h", LoadExtended_out_mem, o.mr ? exp_load(rdata, o) : 32'd0); end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (all_out !== '0) begin failures++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    checks++; if ({DMEM_req, stall_out_mem} !== 2'b00) begin failures++; $display("FAIL reset_req_stall: got %b want 00", {DMEM_req, stall_out_mem}); end
    RST = 1'b1;
  endtask

  task automatic test_nonmem;
    op_t o = mk_op(0, 0, 2'd2, 0, 32'h1234, 32'h0, 1);
    exec_op(o, 0, 32'h0);
    checks++; if ({ALUOutput_out_mem, WEN_out_mem} !== {32'h1234, 1'b1}) begin failures++; $display("FAIL nonmem_alu: got %h/%b want 00001234/1", ALUOutput_out_mem, WEN_out_mem); end
  endtask

  task automatic test_loads;
    op_t o = mk_op(1, 0, 2'd0, 1, 32'h103, 32'h0, 1);
    exec_op(o, 3, 32'h80FFFFFF);
    checks++; if (LoadExtended_out_mem !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_signed: got %h want FFFFFF80", LoadExtended_out_mem); end
    o = mk_op(1, 0, 2'd1, 0, 32'h102, 32'h0, 1);
    exec_op(o, 0, 32'hBEEF0000);
    checks++; if (LoadExtended_out_mem !== 32'h0000BEEF) begin failures++; $display("FAIL lhu: got %h want 0000BEEF", LoadExtended_out_mem); end
  endtask

  task automatic test_store_byte;
    op_t o = mk_op(0, 1, 2'd0, 0, 32'h201, 32'h000000AB, 0);
    exec_op(o, 1, 32'h0);
  endtask

  task automatic test_misaligned;
    op_t o = mk_op(1, 0, 2'd2, 0, 32'h102, 32'h0, 1);
    o.halt = 1'b0;
    exec_op(o, 0, 32'h0);
    o = mk_op(0, 1, 2'd1, 0, 32'h301, 32'h1234, 0);
    exec_op(o, 0, 32'h0);
  endtask

  task automatic test_timeout;
    op_t o = mk_op(1, 0, 2'd2, 1, 32'h400, 32'h0, 1);
    exec_op(o, 10, 32'h0);
  endtask

  task automatic test_idle_ack;
    @(negedge CLK); valid_in_mem = 1'b0; DMEM_ack = 1'b1; DMEM_rdata = $urandom; #1;
    checks++; if ({DMEM_req, stall_out_mem} !== 2'b00) begin failures++; $display("FAIL idle_ack_req: got %b want 00", {DMEM_req, stall_out_mem}); end
    @(negedge CLK); DMEM_ack = 1'b0; #1;
    checks++; if ({WEN_out_mem, halt_out_mem, fault_out_mem} !== 3'b000) begin failures++; $display("FAIL idle_bubble: got %b want 000", {WEN_out_mem, halt_out_mem, fault_out_mem}); end
  endtask

  task automatic test_reset_busy;
    op_t o = mk_op(1, 0, 2'd2, 0, 32'h500, 32'h0, 1);
    @(negedge CLK); drive(o); valid_in_mem = 1'b1; DMEM_ack = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0; valid_in_mem = 1'b0; #1;
    checks++; if (all_out !== '0) begin failures++; $display("FAIL busy_reset_outputs: got %h want 0", all_out); end
    checks++; if ({DMEM_req, stall_out_mem} !== 2'b00) begin failures++; $display("FAIL busy_reset_req: got %b want 00", {DMEM_req, stall_out_mem}); end
    @(negedge CLK); RST = 1'b1;
    for (int i = 0; i < TIMEOUT + 2; i++) begin
      @(negedge CLK); #1;
      checks++; if ({DMEM_req, WEN_out_mem, halt_out_mem, fault_out_mem} !== 4'b0000) begin failures++; $display("FAIL post_reset_quiet: got %b want 0000", {DMEM_req, WEN_out_mem, halt_out_mem, fault_out_mem}); end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 80; i++) begin
      int kind = $urandom_range(0, 2);
      op_t o = mk_op(kind == 1, kind == 2, 2'($urandom), 1'($urandom), $urandom, $urandom,
                     kind == 2 ? ($urandom_range(0, 3) == 0) : 1'($urandom));
      o.halt = ($urandom_range(0, 7) == 0);
      exec_op(o, $urandom_range(0, TIMEOUT + 1), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_loads();
    test_store_byte();
    test_misaligned();
    test_timeout();
    test_idle_ack();
    test_reset_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_stage.md
IMEM_STAGE -- requirements
Module: imem_stage

Interface
REQ-001 Parameter: TIMEOUT, 255, maximum number of BUSY cycles to wait for DMEM_ack before declaring a bus error (range 1..255).
REQ-002 Port: CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: RST  in  1  asynchronous, active-low reset.
REQ-004 Ports: valid_in_mem in 1; PC_in_mem, Inst_in_mem, ALUOutput_in_mem, Immediate_in_mem, StoreData_in_mem in 32; WBSel_in_mem in 2; Rdst_in_mem in 5; RegWrite_in_mem, MemRead_in_mem, MemWrite_in_mem, MemSigned_in_mem, halt_in_mem in 1; MemSize_in_mem in 2 (00 byte, 01 half, 10 word).
REQ-005 Ports: stall_out_mem out 1, held high while the stage cannot accept a new instruction.
REQ-006 Ports (data memory): DMEM_req out 1; DMEM_we out 1; DMEM_addr out 32, word-aligned; DMEM_wdata out 32; DMEM_be out 4; DMEM_ack in 1; DMEM_rdata in 32.
REQ-007 Ports (to write-back, all registered): PC_out_mem, Inst_out_mem, ALUOutput_out_mem, Immediate_out_mem, LoadExtended_out_mem out 32; WBSel_out_mem out 2; Rdst_out_mem out 5; WEN_out_mem, halt_out_mem, fault_out_mem out 1.

Function
REQ-008 FSM states: IDLE, BUSY.
REQ-009 IDLE, valid_in_mem=0: output register loads a bubble, with WEN_out_mem=0, halt_out_mem=0 and fault_out_mem=0.
REQ-010 IDLE, valid non-memory op (MemRead=MemWrite=0): all inputs latch into the output register on the next edge, and WEN_out_mem=RegWrite_in_mem; latency is 1 cycle and there is no stall.
REQ-011 IDLE, valid aligned memory op: the stage moves to BUSY, captures all inputs internally, and loads a bubble into the output register.
REQ-012 Alignment: a half access is misaligned when addr[0]=1; a word access is misaligned when addr[1:0]!=0; a byte access is never misaligned; MemSize=11 is treated as word.
REQ-013 Misaligned op: no memory request is issued; the next edge loads the output register with WEN_out_mem=0, fault_out_mem=1 and halt_out_mem=1.
REQ-014 BUSY: DMEM_req=1 and DMEM_we=captured MemWrite; DMEM_addr={ALUOutput[31:2],2'b00}; stall_out_mem=1.
REQ-015 Stall also covers the entry cycle: stall_out_mem=1 combinationally in IDLE when a valid aligned memory op is present, so upstream holds its state until completion.
REQ-016 Store byte enables: byte access gives DMEM_be=0001<<addr[1:0] with the data byte replicated into all lanes; half access gives 0011 or 1100 with the halfword replicated; word access gives 1111. For loads, DMEM_be=1111.
REQ-017 BUSY with DMEM_ack=1: the output register loads the captured instruction, and LoadExtended_out_mem is set from the DMEM_rdata lane selected by addr[1:0], zero- or sign-extended per MemSigned; the FSM returns to IDLE and stall drops in the same cycle.
REQ-018 Stores complete with WEN_out_mem=RegWrite, which is normally 0; LoadExtended_out_mem=0 for stores.
REQ-019 A timeout counter clears on entry to BUSY and increments each BUSY cycle without ack; when it reaches TIMEOUT the stage returns to IDLE, drops DMEM_req, and loads the output register with WEN_out_mem=0, fault_out_mem=1 and halt_out_mem=1.
REQ-020 An ack arriving in the same cycle as the timeout wins: the access completes normally.
REQ-021 DMEM_ack while in IDLE is ignored.
REQ-022 halt_in_mem propagates to halt_out_mem on normal completion.

Reset
REQ-023 RST=0 forces the FSM to IDLE, clears the timeout counter, and zeroes every registered output and the internal capture registers, with DMEM_req=0 and stall_out_mem=0.
REQ-024 A reset during BUSY abandons the access; no completion or fault is reported after reset is released.

Structure
REQ-025 The shared defines file holds the MemSize encodings and the WBSel_* codes; WBSel is passed through untouched.
REQ-026 One sub-module, load_align, is combinational and takes rdata, addr[1:0], size and signed, producing the 32-bit extended value.

Verification
REQ-027 Non-memory op, ALUOutput=0x1234, RegWrite=1 -> next cycle ALUOutput_out=0x1234 and WEN_out=1, with stall never asserted.
REQ-028 LB with addr=0x103, signed, rdata=0x80FFFFFF, ack after 3 cycles -> stall asserted for 4 cycles, then LoadExtended_out=0xFFFFFF80.
REQ-029 LHU with addr=0x102, rdata=0xBEEF0000, immediate ack -> LoadExtended_out=0x0000BEEF.
REQ-030 SB with addr=0x201, StoreData=0xAB -> DMEM_be=0010, DMEM_wdata=0xABABABAB, DMEM_addr=0x200.
REQ-031 LW with addr=0x102 -> DMEM_req never asserted; fault_out=1, halt_out=1, WEN_out=0.
REQ-032 TIMEOUT=4 with no ack -> fault after 4 BUSY cycles; a repeat run with reset asserted in BUSY cycle 2 gives all outputs 0 and no fault.
